// File: rtl/input_delay_fifo.sv
// input_delay_fifo: FIFO whose entries become readable DELAY cycles after acceptance; define INPUT_DELAY_FIFO_STATS_EN to build the saturating drop counter
module input_delay_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int DELAY  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level, r_elig;
  logic [DELAY-1:0]  r_chain;
  logic              r_overflow;
  logic              w_full, w_exit, w_push, w_pop, w_drop;
  // Handshake decode; a sample leaving the chain is poppable in its exit cycle
  always_comb begin
    w_full    = r_level == LW'(DEPTH);
    w_exit    = r_chain[DELAY-1];
    in_ready  = rst_n & ~w_full & ~flush;
    out_valid = (r_elig != '0) | w_exit;
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready & ~flush;
    w_drop    = in_valid & w_full & ~flush;
    out_data  = r_mem[r_rd_ptr];
    level     = r_level;
    overflow  = r_overflow;
  end
  // Sample storage, zeroed on reset so out_data reads 0 while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end
  // Pointers, occupancy, eligible count and delay chain; flush beats push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_elig     <= '0;
      r_chain    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_elig     <= '0;
      r_chain    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_level    <= r_level + LW'(w_push) - LW'(w_pop);
      r_elig     <= r_elig + LW'(w_exit) - LW'(w_pop);
      r_chain    <= (r_chain << 1) | DELAY'(w_push);
      r_overflow <= r_overflow | w_drop;
    end
  end
`ifdef INPUT_DELAY_FIFO_STATS_EN
  logic [15:0] r_drop_cnt;
  // Saturating count of samples refused while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else if (flush) r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_input_delay_fifo.sv
// tb_input_delay_fifo: vector table on a small wrap instance plus scoreboarded sequences on the default instance
module tb_input_delay_fifo;
`ifdef INPUT_DELAY_FIFO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, overflow;
  logic [31:0] out_data;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic        w_flush = 0, w_in_valid = 0, w_out_ready = 0;
  logic [7:0]  w_in_data = '0;
  logic        w_in_ready, w_out_valid, w_overflow;
  logic [7:0]  w_out_data;
  logic [2:0]  w_level;
  logic [15:0] w_drop_cnt;
  input_delay_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  input_delay_fifo #(.DATA_W(8), .DEPTH(4), .DELAY(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_data(w_in_data),
    .in_ready(w_in_ready), .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(w_out_ready),
    .level(w_level), .overflow(w_overflow), .drop_cnt(w_drop_cnt)
  );
  typedef struct {
    logic       fl, iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic [2:0] e_lvl;
    logic       e_ovf;
  } vec_t;
  vec_t vt [13];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, first_ov = -1, last_pop = -1, max_level = 0;
  int w_first = -1, w_last = -1, w_pops = 0;
  bit w_sb_en = 0;
  logic [31:0] sb [$];
  logic [7:0]  sb_w [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("out_data", out_data, sb.pop_front());
      last_pop = cyc;
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (int'(level) > max_level) max_level = int'(level);
    if (w_sb_en && w_out_valid && w_out_ready) begin
      if (sb_w.size() == 0) chk("wrap_sb_underflow", 1, 0);
      else chk("wrap_out_data", w_out_data, sb_w.pop_front());
      if (w_first < 0) w_first = cyc;
      w_last = cyc;
      w_pops++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    mon();
    adv();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    w_flush = 0; w_in_valid = 0; w_in_data = '0; w_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0; first_ov = -1; last_pop = -1; max_level = 0;
    sb.delete();
    sb_w.delete();
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd2, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd3, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 8'hA6, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA6, 3'd1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    vt[11] = '{1'b1, 1'b1, 8'hA7, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      w_flush = vt[i].fl; w_in_valid = vt[i].iv; w_in_data = vt[i].id; w_out_ready = vt[i].ordy;
      mon();
      chk($sformatf("vec%0d_in_ready", i), w_in_ready, vt[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), w_out_valid, vt[i].e_ov);
      chk($sformatf("vec%0d_level", i), w_level, vt[i].e_lvl);
      chk($sformatf("vec%0d_overflow", i), w_overflow, vt[i].e_ovf);
      if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), w_out_data, vt[i].e_od);
      adv();
    end
    w_sb_en = 1; cyc = 0;
    for (int i = 0; i < 13; i++) begin
      w_in_valid = (i < 10); w_in_data = 8'h50 + 8'(i); w_out_ready = 1;
      if (i < 10) sb_w.push_back(8'h50 + 8'(i));
      step();
    end
    chk("wrap_first_out", w_first, 1);
    chk("wrap_last_out", w_last, 10);
    chk("wrap_pops", w_pops, 10);
    chk("wrap_sb_drained", sb_w.size(), 0);
    w_sb_en = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      in_valid = (i < 20); in_data = 32'(i); out_ready = 1;
      if (i < 20) sb.push_back(32'(i));
      mon();
      if (i == 0) chk("first_push_ready", in_ready, 1);
      adv();
    end
    chk("latency_first_valid", first_ov, 15);
    chk("stream_last_pop", last_pop, 34);
    chk("stream_peak_level", max_level, 15);
    chk("stream_sb_drained", sb.size(), 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 32'hB000 + 32'(i);
      sb.push_back(32'hB000 + 32'(i));
      step();
    end
    in_valid = 1; in_data = 32'hDEAD;
    mon();
    chk("full_in_ready", in_ready, 0);
    chk("full_level", level, 16);
    chk("pre_drop_overflow", overflow, 0);
    adv();
    in_valid = 0;
    mon();
    chk("drop_overflow", overflow, 1);
    chk("drop_cnt_1", drop_cnt, STATS);
    adv();
    repeat (14) step();
    in_valid = 1; in_data = 32'hC0DE; out_ready = 1;
    mon();
    chk("full_all_eligible", out_valid, 1);
    chk("full_simul_in_ready", in_ready, 0);
    chk("full_simul_level", level, 16);
    adv();
    in_valid = 1; in_data = 32'hC0DF; out_ready = 0;
    sb.push_back(32'hC0DF);
    mon();
    chk("after_pop_level", level, 15);
    chk("after_pop_in_ready", in_ready, 1);
    adv();
    in_valid = 0;
    mon();
    chk("refill_level", level, 16);
    adv();
    out_ready = 1;
    repeat (40) step();
    chk("backpressure_sb_drained", sb.size(), 0);
    chk("overflow_sticky", overflow, 1);
    chk("drop_cnt_2", drop_cnt, 2 * STATS);
    cyc = 0; first_ov = -1;
    for (int i = 0; i < 25; i++) begin
      in_valid = (i < 5); in_data = 32'hF00 + 32'(i); flush = (i == 3); out_ready = 1;
      if (i == 4) sb.push_back(32'hF04);
      mon();
      if (i == 3) begin
        chk("preflush_level", level, 3);
        chk("flush_in_ready", in_ready, 0);
      end
      if (i == 4) begin
        chk("postflush_level", level, 0);
        chk("postflush_overflow", overflow, 0);
        chk("postflush_drop_cnt", drop_cnt, 0);
      end
      adv();
    end
    flush = 0;
    chk("flush_first_valid", first_ov, 19);
    chk("flush_sb_drained", sb.size(), 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = 32'hD0 + 32'(i);
      step();
    end
    in_valid = 0;
    repeat (10) step();
    mon();
    chk("prereset_level", level, 8);
    chk("prereset_out_valid", out_valid, 1);
    chk("prereset_out_data", out_data, 32'hD0);
    adv();
    rst_n = 0;
    #2;
    chk("async_in_ready", in_ready, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_level", level, 0);
    chk("async_overflow", overflow, 0);
    chk("async_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1; cyc = 0; first_ov = -1; sb.delete();
    in_valid = 1; in_data = 32'h77; out_ready = 1;
    sb.push_back(32'h77);
    step();
    in_valid = 0;
    repeat (20) step();
    chk("post_reset_latency", first_ov, 15);
    chk("post_reset_sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_delay_fifo.md
INPUT_DELAY_FIFO -- requirements
Module: input_delay_fifo

Interface
REQ-001 Parameter DATA_W, default 32: sample width in bits (1..64).
REQ-002 Parameter DEPTH, default 16: storage entries; power of two, 4..256.
REQ-003 Parameter DELAY, default 15: minimum cycles from acceptance to output eligibility (1..255).
REQ-004 Port clk  input  1: single clock; all state on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port flush  input  1: synchronous clear of all contents and flags.
REQ-007 Port in_valid  input  1: producer presents a sample.
REQ-008 Port in_data  input  DATA_W: input sample.
REQ-009 Port in_ready  output  1: storage can accept a sample this cycle.
REQ-010 Port out_valid  output  1: the head sample is eligible and present.
REQ-011 Port out_data  output  DATA_W: head sample.
REQ-012 Port out_ready  input  1: consumer takes the head sample.
REQ-013 Port level  output  $clog2(DEPTH)+1: stored entry count.
REQ-014 Port overflow  output  1: sticky; set when a sample is offered while the FIFO is full.
REQ-015 Port drop_cnt  output  16: count of dropped samples (see Configuration).

Function
REQ-016 A push occurs when in_valid=1, in_ready=1, and flush=0; in_data is written at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-017 in_ready is 1 when level<DEPTH and flush=0; it is 0 when level==DEPTH.
REQ-018 Each push enters a DELAY-stage valid shift chain; when a push leaves the chain after exactly DELAY cycles, the eligible count increments.
REQ-019 out_valid is 1 when the eligible count is nonzero; out_data is storage[rd_ptr], read combinationally.
REQ-020 A pop occurs when out_valid=1, out_ready=1, and flush=0; rd_ptr advances modulo DEPTH, and the eligible count decrements.
REQ-021 Latency: with out_ready held at 1, a sample pushed in cycle N is presented with out_valid=1 in cycle N+DELAY.
REQ-022 Under backpressure (out_ready=0), eligible samples are held in order and none are lost; samples stay eligible until popped.
REQ-023 When a push and a pop occur in the same cycle, level is unchanged; this includes the case level==DEPTH, where a pop frees an entry only for the next cycle.
REQ-024 When a chain exit and a pop occur in the same cycle, the eligible count is unchanged.
REQ-025 Pointer wrap-around is transparent; data order is strictly first-in, first-out.
REQ-026 When in_valid=1, in_ready=0, and flush=0, the sample is dropped, storage is unchanged, and overflow is set to 1.
REQ-027 flush=1 clears the following in one cycle and takes priority over a simultaneous push or pop: pointers, level, eligible count, shift chain, overflow, and drop_cnt.
REQ-028 Samples in the chain at flush never become eligible.

Reset
REQ-029 rst_n=0 asynchronously clears the following: pointers, level, eligible count, all chain stages, overflow, and drop_cnt.
REQ-030 In reset, the outputs are: in_ready=0, out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
REQ-031 The storage array is cleared to 0 on reset.
REQ-032 Reset asserted mid-operation discards all in-flight and stored samples.
REQ-033 The first push is accepted in the first rising edge after rst_n is deasserted.

Configuration
REQ-034 With macro INPUT_DELAY_FIFO_STATS_EN defined, drop_cnt increments on each dropped sample (REQ-026) and saturates at 16'hFFFF.
REQ-035 Without INPUT_DELAY_FIFO_STATS_EN, drop_cnt is tied to 0 and no counter logic is built; overflow behaviour is identical in both builds.

Verification
REQ-036 Defaults, out_ready=1: push 20 consecutive samples 0..19 from cycle 0 -> out_valid first rises at cycle 15, outputs 0..19 in order on consecutive cycles, and level peaks at 15.
REQ-037 Backpressure: out_ready=0, push 16 samples -> in_ready=0 and level=16; push 17th sample -> overflow=1, drop_cnt=1 (STATS_EN), and sample discarded; out_ready=1 -> 16 samples drain in order.
REQ-038 Full, simultaneous: level=16, all eligible, push and pop in the same cycle -> push refused, pop completes, level=15; next cycle, push accepted.
REQ-039 Wrap: DEPTH=4, DELAY=1, stream 10 samples with out_ready=1 -> ordered output with pointers wrapping twice and no gaps after the first output.
REQ-040 Flush mid-chain: push 5 samples and assert flush at cycle 3 -> level=0, out_valid never asserts for those samples, and overflow=0.
REQ-041 Async reset: assert rst_n=0 between clock edges with level=8 -> outputs go to reset values immediately; after release, a new push emerges after DELAY cycles.
